// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
//
// Round-robin issue scheduler for a pool of sha512 cores, four threads per core.
// Each thread has a ready bit (work pending) and a busy bit (in flight in the
// engine). A pointer walks the thread space in an interleaved order and, when
// it lands on a ready and not-busy thread, offers that thread to the engine
// with a valid/ack handshake.
//
// Thread number layout: {core_num, ctx_num, seq_num}. seq_num is bit 0,
// ctx_num is bit 1 and core_num is the remaining upper bits.
//
// Ports
//   CLK           clock, all state updates on the rising edge
//   reset_n       synchronous active-low reset
//   en            scan enable; low holds the pointer and blocks new offers
//   ready_set_en  strobe: mark thread ready_set_num as ready
//   ready_set_num thread to mark ready (out-of-range numbers are ignored)
//   done_en       strobe: engine finished thread done_num, clear its busy bit
//   done_num      finished thread (out-of-range numbers are ignored)
//   issue_valid   registered; a thread is offered to the engine
//   issue_num     registered; number of the offered thread
//   issue_ack     engine accepts the offer (transfer when valid and ack)
//   idle          registered; no ready bits, no busy bits, no offer pending
// -----------------------------------------------------------------------------
module thread_scheduler #(
    parameter  int N_CORES   = 2,
    parameter  int N_THREADS = 4 * N_CORES,
    localparam int W         = $clog2(N_THREADS)
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         en,
    input  logic         ready_set_en,
    input  logic [W-1:0] ready_set_num,
    input  logic         done_en,
    input  logic [W-1:0] done_num,
    output logic         issue_valid,
    output logic [W-1:0] issue_num,
    input  logic         issue_ack,
    output logic         idle
);

    typedef enum logic {
        SCAN  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [W-1:0]         ptr, ptr_next, ptr_succ;
    logic [W-1:0]         core_cur, core_succ;
    logic                 ctx_succ, seq_succ;
    logic [N_THREADS-1:0] ready, ready_next;
    logic [N_THREADS-1:0] busy, busy_next;
    logic                 issue_valid_next;
    logic [W-1:0]         issue_num_next;
    logic                 idle_next;
    logic                 eligible;
    logic                 transfer;
    logic                 set_ok;
    logic                 done_ok;

    // Successor of ptr: the core number moves fastest so consecutive issues
    // land on different cores; ctx and then seq advance on each core wrap.
    always_comb begin
        core_cur  = ptr >> 2;
        core_succ = core_cur + W'(1);
        ctx_succ  = ptr[1];
        seq_succ  = ptr[0];
        if (core_cur == W'(N_CORES - 1)) begin
            core_succ = '0;
            ctx_succ  = ~ptr[1];
            if (ptr[1]) begin
                seq_succ = ~ptr[0];
            end
        end
        ptr_succ = (core_succ << 2) | W'({ctx_succ, seq_succ});
    end

    // Eligibility uses the registered bits only, so strobes arriving in the
    // same cycle are seen from the following cycle.
    assign eligible = ready[ptr] & ~busy[ptr];
    assign transfer = (state == OFFER) && issue_ack;
    assign set_ok   = ready_set_en && (int'(ready_set_num) < N_THREADS);
    assign done_ok  = done_en && (int'(done_num) < N_THREADS);

    // NOTE: every signal driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        issue_valid_next = issue_valid;
        issue_num_next   = issue_num;
        ready_next       = ready;
        busy_next        = busy;

        case (state)
            SCAN: begin
                if (en) begin
                    ptr_next = ptr_succ;
                    if (eligible) begin
                        issue_valid_next = 1'b1;
                        issue_num_next   = ptr;
                        state_next       = OFFER;
                    end
                end
            end
            OFFER: begin
                // The offer stays up regardless of en until it is accepted.
                if (issue_ack) begin
                    issue_valid_next = 1'b0;
                    state_next       = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase

        if (transfer) begin
            ready_next[issue_num] = 1'b0;
            busy_next[issue_num]  = 1'b1;
        end
        // The transferred thread was not busy, so a done on it is a no-op and
        // cannot undo the busy set above.
        if (done_ok && busy[done_num]) begin
            busy_next[done_num] = 1'b0;
        end
        // Applied last: a ready set wins over the clear from a transfer.
        if (set_ok) begin
            ready_next[ready_set_num] = 1'b1;
        end

        idle_next = ~(|ready) && ~(|busy) && !issue_valid;
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // updates use non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state       <= SCAN;
            ptr         <= '0;
            ready       <= '0;
            busy        <= '0;
            issue_valid <= 1'b0;
            issue_num   <= '0;
            idle        <= 1'b1;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            ready       <= ready_next;
            busy        <= busy_next;
            issue_valid <= issue_valid_next;
            issue_num   <= issue_num_next;
            idle        <= idle_next;
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_scheduler
//
// Self-checking bench for thread_scheduler with N_CORES=2 (8 threads).
// Expected issue numbers are pushed to a scoreboard queue when stimulus is
// driven; every accepted offer pops one entry and compares it.
// -----------------------------------------------------------------------------
module tb_thread_scheduler;

    localparam int N_CORES   = 2;
    localparam int N_THREADS = 4 * N_CORES;
    localparam int W         = 3;

    logic         CLK = 1'b0;
    logic         reset_n;
    logic         en;
    logic         ready_set_en;
    logic [W-1:0] ready_set_num;
    logic         done_en;
    logic [W-1:0] done_num;
    logic         issue_valid;
    logic [W-1:0] issue_num;
    logic         issue_ack;
    logic         idle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    bit spacing_chk = 1'b0;
    bit have_prev   = 1'b0;
    int prev_xfer   = 0;

    thread_scheduler #(
        .N_CORES  (N_CORES),
        .N_THREADS(N_THREADS)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .en           (en),
        .ready_set_en (ready_set_en),
        .ready_set_num(ready_set_num),
        .done_en      (done_en),
        .done_num     (done_num),
        .issue_valid  (issue_valid),
        .issue_num    (issue_num),
        .issue_ack    (issue_ack),
        .idle         (idle)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // One clock cycle. At the falling edge the accepted offer (if any) is
    // compared against the scoreboard; inputs change 1 time unit after the
    // rising edge.
    task automatic tick();
        int e;
        @(negedge CLK);
        if (reset_n && issue_valid && issue_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue: got issue_num=%0d, expected no issue", issue_num);
            end else begin
                e = exp_q.pop_front();
                if (issue_num !== W'(e)) begin
                    failures++;
                    $display("FAIL issue_order: got issue_num=%0d, expected %0d", issue_num, e);
                end
            end
            if (spacing_chk) begin
                if (have_prev) begin
                    checks++;
                    if (cyc - prev_xfer != 2) begin
                        failures++;
                        $display("FAIL issue_spacing: got %0d cycles, expected 2", cyc - prev_xfer);
                    end
                end
                have_prev = 1'b1;
                prev_xfer = cyc;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        en            = 1'b0;
        ready_set_en  = 1'b0;
        ready_set_num = '0;
        done_en       = 1'b0;
        done_num      = '0;
        issue_ack     = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_ready(input int n);
        ready_set_en  = 1'b1;
        ready_set_num = W'(n);
        tick();
        ready_set_en  = 1'b0;
    endtask

    task automatic send_done(input int n);
        done_en  = 1'b1;
        done_num = W'(n);
        tick();
        done_en  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d issues still pending, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_issue_valid: got %b, expected 0", issue_valid);
        end
        checks++;
        if (issue_num !== 3'd0) begin
            failures++;
            $display("FAIL reset_issue_num: got %0d, expected 0", issue_num);
        end
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: got %b, expected 1", idle);
        end
    endtask

    task automatic test_order();
        int ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        do_reset();
        for (int i = 0; i < N_THREADS; i++) set_ready(i);
        foreach (ord[i]) exp_q.push_back(ord[i]);
        issue_ack   = 1'b1;
        spacing_chk = 1'b1;
        have_prev   = 1'b0;
        en          = 1'b1;
        tick();
        checks++;
        if ({issue_valid, issue_num} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL order_first_latency: got valid=%b num=%0d, expected valid=1 num=0",
                     issue_valid, issue_num);
        end
        wait_drain("order", 40);
        spacing_chk = 1'b0;
        for (int i = 0; i < N_THREADS; i++) send_done(i);
        checks++;
        if (idle !== 1'b0) begin
            failures++;
            $display("FAIL idle_late: got %b right after last done, expected 0", idle);
        end
        tick();
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL idle_set: got %b one cycle after last done, expected 1", idle);
        end
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    task automatic test_skip();
        int n = 0;
        do_reset();
        set_ready(6);
        issue_ack = 1'b0;
        en        = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (issue_valid) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL skip_latency: got %0d cycles, expected 4", n);
        end
        checks++;
        if (issue_num !== 3'd6) begin
            failures++;
            $display("FAIL skip_num: got %0d, expected 6", issue_num);
        end
        exp_q.push_back(6);
        issue_ack = 1'b1;
        wait_drain("skip", 5);
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ready(4);
        set_ready(2);
        issue_ack = 1'b0;
        en        = 1'b1;
        tick();
        tick();
        checks++;
        if ({issue_valid, issue_num} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL bp_offer: got valid=%b num=%0d, expected valid=1 num=4", issue_valid, issue_num);
        end
        for (int k = 0; k < 5; k++) begin
            en = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({issue_valid, issue_num} !== {1'b1, 3'd4}) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got valid=%b num=%0d, expected valid=1 num=4",
                         k, issue_valid, issue_num);
            end
        end
        en = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(2);
        issue_ack = 1'b1;
        tick();
        checks++;
        if (exp_q.size() != 1 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_transfer: got pending=%0d valid=%b, expected pending=1 valid=0",
                     exp_q.size(), issue_valid);
        end
        tick();
        checks++;
        if ({issue_valid, issue_num} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL bp_ptr_held: got valid=%b num=%0d, expected valid=1 num=2", issue_valid, issue_num);
        end
        wait_drain("bp", 4);
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    task automatic test_busy();
        int seen = 0;
        do_reset();
        set_ready(0);
        exp_q.push_back(0);
        issue_ack = 1'b1;
        en        = 1'b1;
        wait_drain("busy_first", 10);
        set_ready(0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (issue_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL busy_no_reissue: got %0d valid cycles, expected 0", seen);
        end
        exp_q.push_back(0);
        send_done(0);
        wait_drain("busy_reissue", 20);
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    task automatic test_collision();
        int seen = 0;
        bit found = 1'b0;
        do_reset();
        set_ready(2);
        issue_ack = 1'b0;
        en        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (issue_valid) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || issue_num !== 3'd2) begin
            failures++;
            $display("FAIL coll_offer: got found=%b num=%0d, expected found=1 num=2", found, issue_num);
        end
        exp_q.push_back(2);
        issue_ack     = 1'b1;
        ready_set_en  = 1'b1;
        ready_set_num = 3'd2;
        tick();
        ready_set_en  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (issue_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL coll_busy_held: got %0d valid cycles, expected 0", seen);
        end
        exp_q.push_back(2);
        send_done(2);
        wait_drain("coll_reissue", 20);
        // done and ready set on the same thread in one cycle
        exp_q.push_back(2);
        done_en       = 1'b1;
        done_num      = 3'd2;
        ready_set_en  = 1'b1;
        ready_set_num = 3'd2;
        tick();
        done_en       = 1'b0;
        ready_set_en  = 1'b0;
        wait_drain("coll_done_set", 20);
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    task automatic test_reset_offer();
        do_reset();
        set_ready(0);
        issue_ack = 1'b0;
        en        = 1'b1;
        tick();
        checks++;
        if ({issue_valid, issue_num} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL ro_offer: got valid=%b num=%0d, expected valid=1 num=0", issue_valid, issue_num);
        end
        reset_n       = 1'b0;
        ready_set_en  = 1'b1;
        ready_set_num = 3'd0;
        tick();
        checks++;
        if ({issue_valid, idle} !== 2'b01) begin
            failures++;
            $display("FAIL ro_reset: got valid=%b idle=%b, expected valid=0 idle=1", issue_valid, idle);
        end
        reset_n      = 1'b1;
        ready_set_en = 1'b0;
        en           = 1'b0;
        tick();
        tick();
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL ro_strobe_ignored: got idle=%b, expected 1", idle);
        end
        set_ready(4);
        set_ready(0);
        en = 1'b1;
        tick();
        checks++;
        if ({issue_valid, issue_num} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL ro_ptr_restart: got valid=%b num=%0d, expected valid=1 num=0", issue_valid, issue_num);
        end
        exp_q.push_back(0);
        exp_q.push_back(4);
        issue_ack = 1'b1;
        wait_drain("ro", 20);
        issue_ack = 1'b0;
        en        = 1'b0;
    endtask

    initial begin
        test_reset();
        test_order();
        test_skip();
        test_backpressure();
        test_busy();
        test_collision();
        test_reset_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 The module SHALL have parameter N_CORES, default 2, giving the number of sha512 cores; legal values are 1 or more.
REQ-002 The module SHALL have parameter N_THREADS, default 4*N_CORES, giving the total thread count; it SHALL equal 4*N_CORES.
REQ-003 Thread number layout SHALL be {core_num, ctx_num, seq_num}: seq_num is bit 0, ctx_num is bit 1, core_num is the upper bits.
REQ-004 Port CLK, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset; it SHALL be synchronous and active-low.
REQ-006 Port en, input, 1 bit: scan enable; when low, the pointer SHALL hold and no new issue SHALL start.
REQ-007 Port ready_set_en, input, 1 bit: strobe that marks thread ready_set_num as ready.
REQ-008 Port ready_set_num, input, MSB(N_THREADS-1)+1 bits: number of the thread to mark ready.
REQ-009 Port done_en, input, 1 bit: strobe indicating the engine finished thread done_num.
REQ-010 Port done_num, input, MSB(N_THREADS-1)+1 bits: number of the finished thread.
REQ-011 Port issue_valid, output, 1 bit: registered; a thread is offered to the engine.
REQ-012 Port issue_num, output, MSB(N_THREADS-1)+1 bits: registered; number of the offered thread.
REQ-013 Port issue_ack, input, 1 bit: the engine accepts the offer; a transfer occurs when issue_valid and issue_ack are both high.
REQ-014 Port idle, output, 1 bit: registered; high when no ready bit is set, no busy bit is set and issue_valid is low.

Function
REQ-015 The module SHALL hold per-thread registers ready[N_THREADS] and busy[N_THREADS], plus a pointer ptr.
- A thread is eligible when ready=1 and busy=0.
REQ-016 ptr SHALL advance along this successor sequence:
- core_num increments, wrapping from N_CORES-1 to 0.
- ctx_num toggles when core_num==N_CORES-1.
- seq_num toggles when core_num==N_CORES-1 and ctx_num==1.
REQ-017 With N_CORES=2, the successor sequence SHALL be 0,4,2,6,1,5,3,7, then back to 0.
REQ-018 The FSM SHALL have two states, SCAN and OFFER.
REQ-019 In SCAN with en=1:
- If thread ptr is eligible, then on the next cycle issue_valid=1, issue_num=ptr, the state is OFFER and ptr advances.
- Otherwise ptr advances by one step and the state stays SCAN.
REQ-020 In SCAN with en=0, ptr SHALL hold and the state SHALL stay SCAN.
REQ-021 In OFFER, issue_valid and issue_num SHALL hold stable until issue_ack=1.
REQ-022 On the transfer cycle, the next cycle SHALL have issue_valid=0, state SCAN, ready[issue_num]=0 and busy[issue_num]=1.
REQ-023 Issue throughput SHALL be at most one thread per 2 cycles.
REQ-024 The latency from an eligible ptr in SCAN to issue_valid high SHALL be 1 cycle.
REQ-025 en falling while in OFFER SHALL NOT withdraw the offer.
REQ-026 ready_set_en=1 SHALL set ready[ready_set_num]=1 on the next cycle.
- A set on a busy thread SHALL be kept; the thread becomes eligible once busy clears.
REQ-027 done_en=1 SHALL clear busy[done_num] on the next cycle.
- done_en on a thread that is not busy SHALL have no effect.
REQ-028 ready_set_en for the thread being transferred in the same cycle SHALL leave ready=1, because the set wins over the transfer clear.
REQ-029 done_en and ready_set_en on the same thread in the same cycle SHALL both take effect: busy=0 and ready=1.
REQ-030 Eligibility of the thread at ptr SHALL be evaluated on the register values, so ready/done strobes in the same cycle take effect from the next cycle.
REQ-031 An out-of-range ready_set_num or done_num (N_THREADS or above) SHALL be ignored.
REQ-032 idle SHALL reflect state one cycle late, because it is registered.

Reset
REQ-033 While reset_n=0 at a rising CLK edge, the module SHALL set ready=0, busy=0, ptr=0, state SCAN, issue_valid=0, issue_num=0 and idle=1.
REQ-034 Reset asserted while in OFFER SHALL drop issue_valid on the next cycle, and no transfer SHALL be recorded.
REQ-035 Strobes sampled while reset_n=0 SHALL be ignored.

Verification
REQ-036 Order test (N_CORES=2): after reset, set ready on all 8 threads, en=1, issue_ack held high -> issue_num order 0,4,2,6,1,5,3,7, with one issue every 2 cycles.
REQ-037 Skip test: only thread 6 ready, ptr=0 -> issue_valid rises 4 cycles after en after the pointer scans 0, 4 and 2; issue_num=6.
REQ-038 Backpressure test: issue_ack low for 5 cycles during OFFER of thread 4 -> issue_valid and issue_num=4 stay stable; ptr does not advance; transfer occurs on the ack cycle.
REQ-039 Busy test: thread 0 issued, then ready set on 0 again with no done -> thread 0 is not reissued; after done_en with done_num=0, it is reissued on the next pass of ptr.
REQ-040 Collision test: ready_set_num=2 on the transfer cycle of thread 2 -> ready[2]=1 and busy[2]=1; after done on 2, thread 2 is issued again.
REQ-041 Reset test: reset_n low while in OFFER -> next cycle issue_valid=0, idle=1, and ptr restarts at 0.
